// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: key debounce, mode FSM and timing strobes for the
// HH:MM:SS clock / stopwatch datapath.
// Optional feature macro: SET_TIMEOUT_EN (set modes fall back to RUN after
// IDLE_SEC seconds without a key press).
module clock_mode_ctrl #(
  parameter int TICK_DIV       = 50_000_000,
  parameter int SCAN_DIV       = 1_000_000,
  parameter int HOLD_SAMPLES   = 50,
  parameter int REPEAT_SAMPLES = 10,
  parameter int IDLE_SEC       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_add_n,
  input  logic       key_sub_n,
  input  logic       key_mode_n,
  output logic [1:0] mode,
  output logic       sec_tick,
  output logic       sec_clr,
  output logic       min_inc,
  output logic       min_dec,
  output logic       hr_inc,
  output logic       hr_dec,
  output logic       cs_tick,
  output logic       sw_run,
  output logic       sw_clr,
  output logic       disp_sel,
  output logic [5:0] blink_mask
);

  localparam int CS_DIV = TICK_DIV / 100;
  localparam int SEC_W  = $clog2(TICK_DIV);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CS_W   = (CS_DIV > 1) ? $clog2(CS_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_SAMPLES + REPEAT_SAMPLES + 1);

  // Reject parameter sets the counters cannot honour.
  if ((TICK_DIV % 100) != 0 || TICK_DIV < 200 || SCAN_DIV < 1 ||
      HOLD_SAMPLES < 1 || REPEAT_SAMPLES < 1 || IDLE_SEC < 1) begin : g_bad_params
    $error("clock_mode_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_MIN = 2'b01,
    MODE_SET_HR  = 2'b10,
    MODE_SW      = 2'b11
  } mode_t;

  // ---------------- key input path ----------------
  // bit0 = add, bit1 = sub, bit2 = mode; all active-low
  logic [2:0] key_raw;
  logic [2:0] key_sync;
  assign key_raw = {key_mode_n, key_sub_n, key_add_n};

  for (genvar gi = 0; gi < 3; gi++) begin : g_sync
    logic s1_reg;
    logic s2_reg;
    // Two-flop synchroniser; idles high so a released key never looks pressed
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_reg <= 1'b1;
        s2_reg <= 1'b1;
      end else begin
        s1_reg <= key_raw[gi];
        s2_reg <= s1_reg;
      end
    end
    assign key_sync[gi] = s2_reg;
  end

  logic [SCAN_W-1:0] scan_cnt_reg;
  logic [2:0]        samp_reg;
  logic [2:0]        samp_d_reg;
  logic              samp_tick_reg;   // high in the cycle samp_reg holds a fresh sample
  logic              scan_wrap;
  assign scan_wrap = (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1));

  // Slow key sampling gives the debounce; samp_d lags one cycle for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_reg  <= '0;
      samp_reg      <= 3'b111;
      samp_d_reg    <= 3'b111;
      samp_tick_reg <= 1'b0;
    end else begin
      samp_d_reg    <= samp_reg;
      samp_tick_reg <= scan_wrap;
      if (scan_wrap) begin
        scan_cnt_reg <= '0;
        samp_reg     <= key_sync;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
      end
    end
  end

  logic [2:0] press;
  logic       held_add;
  logic       held_sub;
  logic       mode_press;
  assign press      = samp_d_reg & ~samp_reg;
  assign held_add   = ~samp_reg[0];
  assign held_sub   = ~samp_reg[1];
  assign mode_press = press[2];

  // ---------------- timebases ----------------
  logic [SEC_W-1:0] sec_cnt_reg, sec_cnt_next;
  logic [CS_W-1:0]  cs_cnt_reg, cs_cnt_next;
  logic             sec_wrap, cs_wrap, blink_ph_next;
  assign sec_wrap      = (sec_cnt_reg == SEC_W'(TICK_DIV - 1));
  assign sec_cnt_next  = sec_wrap ? '0 : sec_cnt_reg + SEC_W'(1);
  assign blink_ph_next = (sec_cnt_next >= SEC_W'(TICK_DIV / 2));
  assign cs_wrap       = (cs_cnt_reg == CS_W'(CS_DIV - 1));

  // ---------------- mode FSM ----------------
  mode_t             mode_reg, mode_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic              hold_key_reg, hold_key_next;   // 0 = add held, 1 = sub held
  logic              sw_run_reg, sw_run_next;
  logic              sec_tick_reg, sec_clr_reg, min_inc_reg, min_dec_reg;
  logic              hr_inc_reg, hr_dec_reg, cs_tick_reg, sw_clr_reg, disp_sel_reg;
  logic [5:0]        blink_mask_reg, blink_mask_next;
  logic              sec_tick_next, sec_clr_next, sw_clr_next;
  logic              fld_stb, fld_dec;
`ifdef SET_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_SEC + 1);
  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
`endif

  // Next-state and strobe decode; mode press outranks add/sub, add+sub cancels
  always_comb begin
    mode_next     = mode_reg;
    hold_cnt_next = hold_cnt_reg;
    hold_key_next = hold_key_reg;
    sw_run_next   = sw_run_reg;
    sec_clr_next  = 1'b0;
    sw_clr_next   = 1'b0;
    fld_stb       = 1'b0;
    fld_dec       = 1'b0;
    // a RUN->SET_MIN transition clears seconds, so its tick is dropped
    sec_tick_next = sec_wrap &&
                    (mode_reg == MODE_SW || (mode_reg == MODE_RUN && !mode_press));
`ifdef SET_TIMEOUT_EN
    idle_cnt_next = idle_cnt_reg;
`endif
    if (mode_press) begin
      mode_next     = mode_t'(mode_reg + 2'd1);
      hold_cnt_next = '0;
      if (mode_reg == MODE_RUN) sec_clr_next = 1'b1;
    end else begin
      case (mode_reg)
        MODE_SET_MIN, MODE_SET_HR: begin
          if (samp_tick_reg) begin
            if (held_add ^ held_sub) begin
              if (press[0] | press[1]) begin
                hold_cnt_next = HOLD_W'(1);
                hold_key_next = held_sub;
                fld_stb       = 1'b1;
              end else if (hold_cnt_reg != '0 && held_sub == hold_key_reg) begin
                if (hold_cnt_reg == HOLD_W'(HOLD_SAMPLES + REPEAT_SAMPLES - 1)) begin
                  hold_cnt_next = HOLD_W'(HOLD_SAMPLES);
                  fld_stb       = 1'b1;
                end else begin
                  hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                  if (hold_cnt_reg == HOLD_W'(HOLD_SAMPLES - 1)) fld_stb = 1'b1;
                end
              end else begin
                hold_cnt_next = '0;
              end
            end else begin
              hold_cnt_next = '0;
            end
          end
          fld_dec = hold_key_next;
        end
        MODE_SW: begin
          hold_cnt_next = '0;
          if (press[0] && !held_sub) begin
            sw_run_next = ~sw_run_reg;
          end else if (press[1] && !held_add && !sw_run_reg) begin
            sw_clr_next = 1'b1;
          end
        end
        default: begin
          hold_cnt_next = '0;
        end
      endcase
    end
`ifdef SET_TIMEOUT_EN
    if ((mode_reg == MODE_SET_MIN || mode_reg == MODE_SET_HR) && !mode_press) begin
      if (|press) begin
        idle_cnt_next = '0;
      end else if (sec_wrap) begin
        if (idle_cnt_reg == IDLE_W'(IDLE_SEC - 1)) begin
          mode_next     = MODE_RUN;
          idle_cnt_next = '0;
          hold_cnt_next = '0;
          fld_stb       = 1'b0;
        end else begin
          idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
        end
      end
    end else begin
      idle_cnt_next = '0;
    end
`endif
    if (mode_next != MODE_SW) sw_run_next = 1'b0;

    cs_cnt_next = cs_cnt_reg;
    if (sw_clr_next)     cs_cnt_next = '0;
    else if (sw_run_reg) cs_cnt_next = cs_wrap ? '0 : cs_cnt_reg + CS_W'(1);

    blink_mask_next = 6'b000000;
    if (blink_ph_next && mode_next == MODE_SET_MIN) blink_mask_next = 6'b001100;
    if (blink_ph_next && mode_next == MODE_SET_HR)  blink_mask_next = 6'b110000;
  end

  // State register with all outputs registered from the decoded next values
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg       <= MODE_RUN;
      hold_cnt_reg   <= '0;
      hold_key_reg   <= 1'b0;
      sw_run_reg     <= 1'b0;
      sec_cnt_reg    <= '0;
      cs_cnt_reg     <= '0;
      sec_tick_reg   <= 1'b0;
      sec_clr_reg    <= 1'b0;
      min_inc_reg    <= 1'b0;
      min_dec_reg    <= 1'b0;
      hr_inc_reg     <= 1'b0;
      hr_dec_reg     <= 1'b0;
      cs_tick_reg    <= 1'b0;
      sw_clr_reg     <= 1'b0;
      disp_sel_reg   <= 1'b0;
      blink_mask_reg <= 6'b000000;
`ifdef SET_TIMEOUT_EN
      idle_cnt_reg   <= '0;
`endif
    end else begin
      mode_reg       <= mode_next;
      hold_cnt_reg   <= hold_cnt_next;
      hold_key_reg   <= hold_key_next;
      sw_run_reg     <= sw_run_next;
      sec_cnt_reg    <= sec_cnt_next;
      cs_cnt_reg     <= cs_cnt_next;
      sec_tick_reg   <= sec_tick_next;
      sec_clr_reg    <= sec_clr_next;
      min_inc_reg    <= fld_stb && mode_reg == MODE_SET_MIN && !fld_dec;
      min_dec_reg    <= fld_stb && mode_reg == MODE_SET_MIN &&  fld_dec;
      hr_inc_reg     <= fld_stb && mode_reg == MODE_SET_HR  && !fld_dec;
      hr_dec_reg     <= fld_stb && mode_reg == MODE_SET_HR  &&  fld_dec;
      cs_tick_reg    <= sw_run_reg && cs_wrap;
      sw_clr_reg     <= sw_clr_next;
      disp_sel_reg   <= (mode_next == MODE_SW);
      blink_mask_reg <= blink_mask_next;
`ifdef SET_TIMEOUT_EN
      idle_cnt_reg   <= idle_cnt_next;
`endif
    end
  end

  assign mode       = mode_reg;
  assign sec_tick   = sec_tick_reg;
  assign sec_clr    = sec_clr_reg;
  assign min_inc    = min_inc_reg;
  assign min_dec    = min_dec_reg;
  assign hr_inc     = hr_inc_reg;
  assign hr_dec     = hr_dec_reg;
  assign cs_tick    = cs_tick_reg;
  assign sw_run     = sw_run_reg;
  assign sw_clr     = sw_clr_reg;
  assign disp_sel   = disp_sel_reg;
  assign blink_mask = blink_mask_reg;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with small dividers
// (TICK_DIV=200, SCAN_DIV=4, HOLD_SAMPLES=5, REPEAT_SAMPLES=2, IDLE_SEC=3).
module tb_clock_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_add_n = 1'b1;
  logic       key_sub_n = 1'b1;
  logic       key_mode_n = 1'b1;
  logic [1:0] mode;
  logic       sec_tick, sec_clr, min_inc, min_dec, hr_inc, hr_dec;
  logic       cs_tick, sw_run, sw_clr, disp_sel;
  logic [5:0] blink_mask;

  clock_mode_ctrl #(
    .TICK_DIV(200), .SCAN_DIV(4), .HOLD_SAMPLES(5), .REPEAT_SAMPLES(2), .IDLE_SEC(3)
  ) dut (
    .clk(clk), .rst(rst),
    .key_add_n(key_add_n), .key_sub_n(key_sub_n), .key_mode_n(key_mode_n),
    .mode(mode), .sec_tick(sec_tick), .sec_clr(sec_clr),
    .min_inc(min_inc), .min_dec(min_dec), .hr_inc(hr_inc), .hr_dec(hr_dec),
    .cs_tick(cs_tick), .sw_run(sw_run), .sw_clr(sw_clr), .disp_sel(disp_sel),
    .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  logic [17:0] outs;
  assign outs = {mode, sec_tick, sec_clr, min_inc, min_dec, hr_inc, hr_dec,
                 cs_tick, sw_run, sw_clr, disp_sel, blink_mask};

  // pulse counters, sampled mid-cycle
  int n_sec_tick, n_sec_clr, n_min_inc, n_min_dec, n_hr_inc, n_hr_dec;
  int n_cs_tick, n_sw_clr, n_key_strb, n_multi;
  int n_blink_min, n_blink_hr, n_blink_other;

  always @(negedge clk) begin
    if (sec_tick === 1'b1) n_sec_tick <= n_sec_tick + 1;
    if (sec_clr  === 1'b1) n_sec_clr  <= n_sec_clr + 1;
    if (min_inc  === 1'b1) n_min_inc  <= n_min_inc + 1;
    if (min_dec  === 1'b1) n_min_dec  <= n_min_dec + 1;
    if (hr_inc   === 1'b1) n_hr_inc   <= n_hr_inc + 1;
    if (hr_dec   === 1'b1) n_hr_dec   <= n_hr_dec + 1;
    if (cs_tick  === 1'b1) n_cs_tick  <= n_cs_tick + 1;
    if (sw_clr   === 1'b1) n_sw_clr   <= n_sw_clr + 1;
    if ((sec_clr | min_inc | min_dec | hr_inc | hr_dec | sw_clr) === 1'b1)
      n_key_strb <= n_key_strb + 1;
    if ($countones({sec_clr, min_inc, min_dec, hr_inc, hr_dec, sw_clr}) > 1 ||
        (sec_tick & sec_clr) === 1'b1)
      n_multi <= n_multi + 1;
    if (blink_mask === 6'b001100) n_blink_min <= n_blink_min + 1;
    else if (blink_mask === 6'b110000) n_blink_hr <= n_blink_hr + 1;
    else if (blink_mask !== 6'b000000) n_blink_other <= n_blink_other + 1;
  end

  int s_sec_tick, s_sec_clr, s_min_inc, s_min_dec, s_hr_inc, s_hr_dec;
  int s_cs_tick, s_sw_clr, s_key_strb, s_blink_min, s_blink_hr, s_blink_other;
  int checks_n = 0;
  int errors_n = 0;

  task automatic snap();
    s_sec_tick = n_sec_tick; s_sec_clr = n_sec_clr;
    s_min_inc = n_min_inc;   s_min_dec = n_min_dec;
    s_hr_inc = n_hr_inc;     s_hr_dec = n_hr_dec;
    s_cs_tick = n_cs_tick;   s_sw_clr = n_sw_clr;
    s_key_strb = n_key_strb;
    s_blink_min = n_blink_min; s_blink_hr = n_blink_hr; s_blink_other = n_blink_other;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n++;
    assert (obs === exp) else begin
      errors_n++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
    $display("check %-18s observed %0d required %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // hold the chosen keys low for low_cyc cycles, then release and settle
  task automatic press(input bit m, input bit a, input bit s, input int low_cyc);
    key_mode_n = ~m; key_add_n = ~a; key_sub_n = ~s;
    step(low_cyc);
    key_mode_n = 1'b1; key_add_n = 1'b1; key_sub_n = 1'b1;
    step(20);
  endtask

  initial begin
    // ---- reset ----
    step(5);
    check("reset_outs", 32'(outs), 0);
    rst = 1'b0;

    // ---- RUN, keys idle: 5 seconds ticks, nothing else ----
    snap();
    step(1050);
    check("run_sec_ticks", n_sec_tick - s_sec_tick, 5);
    check("run_no_strobe", n_key_strb - s_key_strb, 0);
    check("run_no_blink", (n_blink_min + n_blink_hr + n_blink_other)
                          - (s_blink_min + s_blink_hr + s_blink_other), 0);
    check("run_mode", 32'(mode), 0);

    // ---- enter SET_MIN ----
    snap();
    press(1, 0, 0, 12);
    check("setmin_mode", 32'(mode), 1);
    check("setmin_sec_clr", n_sec_clr - s_sec_clr, 1);
    snap();
    step(400);
    check("setmin_no_tick", n_sec_tick - s_sec_tick, 0);
    check("setmin_blink_on", n_blink_min - s_blink_min, 200);
    check("setmin_blink_bad", (n_blink_hr + n_blink_other) - (s_blink_hr + s_blink_other), 0);

    // single add press, then 38 samples of sub held: 1 + samples 5,7..37
    snap();
    press(0, 1, 0, 12);
    check("min_inc_once", n_min_inc - s_min_inc, 1);
    check("min_inc_no_dec", n_min_dec - s_min_dec, 0);
    snap();
    key_sub_n = 1'b0;
    step(152);
    key_sub_n = 1'b1;
    step(30);
    check("min_dec_repeat", n_min_dec - s_min_dec, 18);
    check("min_dec_no_inc", n_min_inc - s_min_inc, 0);
    snap();
    step(40);
    check("min_dec_stopped", n_min_dec - s_min_dec, 0);

    // ---- SET_HR ----
    press(1, 0, 0, 12);
    check("sethr_mode", 32'(mode), 2);
    snap();
    press(0, 1, 0, 12);
    press(0, 0, 1, 12);
    check("hr_inc_once", n_hr_inc - s_hr_inc, 1);
    check("hr_dec_once", n_hr_dec - s_hr_dec, 1);
    check("hr_no_min", (n_min_inc + n_min_dec) - (s_min_inc + s_min_dec), 0);
    check("hr_no_sec_clr", n_sec_clr - s_sec_clr, 0);
    snap();
    step(400);
    check("sethr_blink_on", n_blink_hr - s_blink_hr, 200);

    // ---- STOPWATCH ----
    press(1, 0, 0, 12);
    check("sw_mode", 32'(mode), 3);
    check("sw_disp_sel", 32'(disp_sel), 1);
    press(0, 1, 0, 12);
    check("sw_run_on", 32'(sw_run), 1);
    snap();
    step(100);
    check("sw_cs_ticks", n_cs_tick - s_cs_tick, 50);
    snap();
    press(0, 0, 1, 12);
    check("sw_clr_ignored", n_sw_clr - s_sw_clr, 0);
    check("sw_still_run", 32'(sw_run), 1);
    press(0, 1, 0, 12);
    check("sw_run_off", 32'(sw_run), 0);
    snap();
    step(50);
    check("sw_cs_held", n_cs_tick - s_cs_tick, 0);
    snap();
    press(0, 0, 1, 12);
    check("sw_clr_once", n_sw_clr - s_sw_clr, 1);
    snap();
    step(400);
    check("sw_sec_ticks", n_sec_tick - s_sec_tick, 2);

    // ---- back to RUN, then simultaneous key cases ----
    press(1, 0, 0, 12);
    check("wrap_mode_run", 32'(mode), 0);
    check("wrap_disp_sel", 32'(disp_sel), 0);
    press(1, 0, 0, 12);
    press(1, 0, 0, 12);
    snap();
    press(1, 1, 0, 12);
    check("mode_add_mode", 32'(mode), 3);
    check("mode_add_no_hr", n_hr_inc - s_hr_inc, 0);
    check("mode_add_run", 32'(sw_run), 0);
    press(1, 0, 0, 12);
    press(1, 0, 0, 12);
    snap();
    press(0, 1, 1, 40);
    check("addsub_no_strb", (n_min_inc + n_min_dec) - (s_min_inc + s_min_dec), 0);
    check("addsub_mode", 32'(mode), 1);

    // ---- idle in SET_MIN ----
    snap();
    step(650);
`ifdef SET_TIMEOUT_EN
    check("idle_mode", 32'(mode), 0);
`else
    check("idle_mode", 32'(mode), 1);
`endif
    check("idle_no_strobe", n_key_strb - s_key_strb, 0);

    // ---- reset in the middle of an auto-repeat hold ----
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    press(1, 0, 0, 12);
    check("rst_pre_mode", 32'(mode), 1);
    key_add_n = 1'b0;
    step(60);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_outs", 32'(outs), 0);
    step(1);
    rst = 1'b0;
    snap();
    step(100);
    check("rst_held_quiet", n_key_strb - s_key_strb, 0);
    key_add_n = 1'b1;
    step(20);

    check("strobe_exclusive", n_multi, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
    $finish;
  end

endmodule
